// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction-fetch stage for the single-cycle core.
// The PC addresses the instruction ROM directly. Fetch latency is zero cycles,
// and one instruction retires per cycle while running.
// Optional feature: define FETCH_CYCLE_COUNT_EN to add a 16-bit saturating
// run-cycle counter on port cycle_count.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | after reset, waiting for start; decoder sees NOPs
// RUN   | executing; pc advances, branches or halts every cycle
// DONE  | HALT retired; pc frozen at HALT address until next start

module fetch_unit #(
  parameter int PC_W   = 10,
  parameter int INST_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] instruction,
  input  logic              ctrl_branch,
  input  logic              take_branch,
  input  logic [PC_W-1:0]   br_target,
  input  logic              halt,
  output logic              run,
  output logic              done,
  output logic [PC_W-1:0]   pc
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]       cycle_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc_next;

  // State and program counter registers; reset returns to IDLE at pc 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next state and next PC. A start pulse wins over halt and branch in every state.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (start) begin
      state_next = RUN;
      pc_next    = start_addr;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state_next = DONE;
          end else if (ctrl_branch && take_branch) begin
            pc_next = br_target;
          end else begin
            pc_next = pc + PC_W'(1);
          end
        end
        IDLE, DONE: begin
          state_next = state;
        end
        default: begin
          state_next = IDLE;
          pc_next    = '0;
        end
      endcase
    end
  end

  // Outputs decoded from state. Outside RUN the decoder is fed a zero (NOP) word.
  always_comb begin
    run         = 1'b0;
    done        = 1'b0;
    instruction = '0;
    case (state)
      RUN: begin
        run         = 1'b1;
        instruction = imem_data;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        run = 1'b0;
      end
    endcase
  end

  assign imem_addr = pc;

`ifdef FETCH_CYCLE_COUNT_EN
  // Run-cycle counter. It is cleared by start and counts every RUN cycle,
  // including the HALT cycle. It saturates at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (start) begin
      cycle_count <= '0;
    end else if (state == RUN && cycle_count != 16'hFFFF) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end
`endif

endmodule
